// File: rtl/serial_line_conditioner_if.sv
// Serial line conditioner pin/output bundle: raw pins in, conditioned levels and strobes out.
interface serial_line_conditioner_if;
    logic RAW_SERIAL_CLOCK;
    logic RAW_SERIAL_DATA;
    logic DEBOUNCED_CLOCK;
    logic DEBOUNCED_DATA;
    logic CLOCK_FALL_STROBE;
    logic CLOCK_RISE_STROBE;
    logic LINE_IDLE;

    // Conditioner side: samples the raw pins, drives the filtered results.
    modport slave (
        input  RAW_SERIAL_CLOCK,
        input  RAW_SERIAL_DATA,
        output DEBOUNCED_CLOCK,
        output DEBOUNCED_DATA,
        output CLOCK_FALL_STROBE,
        output CLOCK_RISE_STROBE,
        output LINE_IDLE
    );

    // Pin driver / consumer side.
    modport master (
        output RAW_SERIAL_CLOCK,
        output RAW_SERIAL_DATA,
        input  DEBOUNCED_CLOCK,
        input  DEBOUNCED_DATA,
        input  CLOCK_FALL_STROBE,
        input  CLOCK_RISE_STROBE,
        input  LINE_IDLE
    );
endinterface

// File: rtl/serial_line_conditioner.sv
// Serial line conditioner: synchronises and debounces the raw serial clock/data
// pins, emits one-cycle edge strobes of the filtered clock and flags bus idle.
module serial_line_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned IDLE_CYCLES     = 64
) (
    input  logic                        CONTROL_CLOCK,
    input  logic                        RESET,
    serial_line_conditioner_if.slave    bus
);
    localparam int unsigned DEB_CNT_W  = 8;
    localparam int unsigned IDLE_CNT_W = 16;
    localparam logic [DEB_CNT_W-1:0]  DEB_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [IDLE_CNT_W-1:0] IDLE_MAX = IDLE_CNT_W'(IDLE_CYCLES);

    logic                   r_clk_meta;
    logic                   r_clk_sync;
    logic                   r_dat_meta;
    logic                   r_dat_sync;
    logic                   r_deb_clk;
    logic                   r_deb_dat;
    logic [DEB_CNT_W-1:0]   r_clk_cnt;
    logic [DEB_CNT_W-1:0]   r_dat_cnt;
    logic [IDLE_CNT_W-1:0]  r_idle_cnt;
    logic                   r_fall;
    logic                   r_rise;
    logic                   r_idle;

    logic                   w_clk_flip;
    logic                   w_dat_flip;
    logic                   w_both_high;

    // A line flips once it has disagreed with its filtered value for the full window.
    assign w_clk_flip  = (r_clk_sync != r_deb_clk) && (r_clk_cnt == DEB_LAST);
    assign w_dat_flip  = (r_dat_sync != r_deb_dat) && (r_dat_cnt == DEB_LAST);
    assign w_both_high = r_deb_clk & r_deb_dat;

    // Two-flop synchronisers; idle-high lines so reset to 1.
    always_ff @(posedge CONTROL_CLOCK) begin
        if (RESET) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= bus.RAW_SERIAL_CLOCK;
            r_clk_sync <= r_clk_meta;
            r_dat_meta <= bus.RAW_SERIAL_DATA;
            r_dat_sync <= r_dat_meta;
        end
    end

    // Serial clock debounce counter and filtered level.
    always_ff @(posedge CONTROL_CLOCK) begin
        if (RESET) begin
            r_deb_clk <= 1'b1;
            r_clk_cnt <= '0;
        end else if (r_clk_sync == r_deb_clk) begin
            r_clk_cnt <= '0;
        end else if (w_clk_flip) begin
            r_deb_clk <= r_clk_sync;
            r_clk_cnt <= '0;
        end else begin
            r_clk_cnt <= r_clk_cnt + DEB_CNT_W'(1);
        end
    end

    // Serial data debounce counter and filtered level.
    always_ff @(posedge CONTROL_CLOCK) begin
        if (RESET) begin
            r_deb_dat <= 1'b1;
            r_dat_cnt <= '0;
        end else if (r_dat_sync == r_deb_dat) begin
            r_dat_cnt <= '0;
        end else if (w_dat_flip) begin
            r_deb_dat <= r_dat_sync;
            r_dat_cnt <= '0;
        end else begin
            r_dat_cnt <= r_dat_cnt + DEB_CNT_W'(1);
        end
    end

    // Edge strobes land on the same edge the filtered clock flips.
    always_ff @(posedge CONTROL_CLOCK) begin
        if (RESET) begin
            r_fall <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_fall <= w_clk_flip &  r_deb_clk;
            r_rise <= w_clk_flip & ~r_deb_clk;
        end
    end

    // Saturating idle counter; idle drops on the first edge either line is seen low.
    always_ff @(posedge CONTROL_CLOCK) begin
        if (RESET) begin
            r_idle_cnt <= '0;
            r_idle     <= 1'b0;
        end else begin
            if (!w_both_high) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != IDLE_MAX) begin
                r_idle_cnt <= r_idle_cnt + IDLE_CNT_W'(1);
            end
            r_idle <= w_both_high && (r_idle_cnt == IDLE_MAX);
        end
    end

    assign bus.DEBOUNCED_CLOCK   = r_deb_clk;
    assign bus.DEBOUNCED_DATA    = r_deb_dat;
    assign bus.CLOCK_FALL_STROBE = r_fall;
    assign bus.CLOCK_RISE_STROBE = r_rise;
    assign bus.LINE_IDLE         = r_idle;
endmodule
